// File: rtl/sfq_xort_drv_pkg.sv
// Shared types and helpers for the clocked-XOR SFQ cell driver.
// Contents: FSM state enum, request payload struct, error-counter width,
//           and the expected-q function for a clocked XOR cell.
package sfq_xort_drv_pkg;

  localparam int unsigned ERRCNT_W = 8;
  localparam int unsigned REQ_W    = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PULSE_A   = 3'd1,
    GAP_A     = 3'd2,
    PULSE_B   = 3'd3,
    GAP_S     = 3'd4,
    PULSE_CLK = 3'd5,
    WAIT_Q    = 3'd6
  } state_e;

  typedef struct packed {
    logic a;
    logic b;
  } req_t;

  // A clocked XOR emits a q pulse when exactly one data pulse was stored.
  function automatic logic exp_q(input logic a, input logic b);
    return a ^ b;
  endfunction

endpackage

// File: rtl/sfq_req_fifo.sv
// Synchronous request FIFO with extra-MSB pointer wrap.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/wdata_i write;
//        pop_i read-advance; rdata_c_o head entry (combinational);
//        full_c_o/empty_c_o occupancy flags (combinational).
// A push while full is accepted only when a pop happens in the same cycle.
module sfq_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_c_o,
  output logic             full_c_o,
  output logic             empty_c_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  // Same index with differing wrap bits means every slot is occupied.
  assign empty_c_o = (wr_ptr_q == rd_ptr_q);
  assign full_c_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok    = pop_i && !empty_c_o;
  assign push_ok   = push_i && (!full_c_o || pop_ok);
  assign rdata_c_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sfq_xort_driver.sv
// Clocked-XOR SFQ cell initiator: queues (a,b) requests, issues toggle-encoded
// a/b/clk pulses with programmable spacing, decodes the returned q toggle.
// Ports: clk/rst_n; req_valid/req_ready/req_a/req_b request side;
//        sfq_a/sfq_b/sfq_clk toggle lines to the cell, sfq_q async return;
//        rsp_valid strobe with rsp_bit (q toggled) and rsp_err (vs a^b);
//        busy while a request is in flight or queued.
// Optional: SFQ_XORT_DRV_ERRCNT_EN adds err_cnt, a saturating rsp_err count.
module sfq_xort_driver
  import sfq_xort_drv_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AB_GAP_CYC = 2,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned LAT_CYC    = 3,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_a,
  input  logic                req_b,
  output logic                sfq_a,
  output logic                sfq_b,
  output logic                sfq_clk,
  input  logic                sfq_q,
  output logic                rsp_valid,
  output logic                rsp_bit,
  output logic                rsp_err,
`ifdef SFQ_XORT_DRV_ERRCNT_EN
  output logic [ERRCNT_W-1:0] err_cnt,
`endif
  output logic                busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  req_t             op_q, op_d, fifo_head;
  logic [REQ_W-1:0] fifo_wdata, fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic             q_s1_q, q_sync_q, q_ref_q, q_ref_d, q_bit;
  logic             sfq_a_q, sfq_b_q, sfq_clk_q;
  logic             tog_a, tog_b, tog_clk;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_bit_q, rsp_bit_d;
  logic             rsp_err_q, rsp_err_d;

  assign fifo_push  = req_valid && !fifo_full;
  assign fifo_wdata = {req_a, req_b};
  assign fifo_head  = req_t'(fifo_rdata);

  sfq_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .push_i    (fifo_push),
    .wdata_i   (fifo_wdata),
    .pop_i     (fifo_pop),
    .rdata_c_o (fifo_rdata),
    .full_c_o  (fifo_full),
    .empty_c_o (fifo_empty)
  );

  assign cnt_dec = cnt_q - CNT_W'(1);
  // q toggled since the clk pulse if the synchronised level moved.
  assign q_bit   = q_sync_q ^ q_ref_q;

  // Next-state and pulse/response decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    q_ref_d     = q_ref_q;
    fifo_pop    = 1'b0;
    tog_a       = 1'b0;
    tog_b       = 1'b0;
    tog_clk     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_bit_d   = rsp_bit_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = fifo_head;
          state_d  = PULSE_A;
        end
      end
      PULSE_A: begin
        tog_a = op_q.a;
        if (op_q.a && op_q.b) begin
          cnt_d   = CNT_W'(AB_GAP_CYC);
          state_d = GAP_A;
        end else begin
          state_d = PULSE_B;
        end
      end
      GAP_A: begin
        cnt_d = cnt_dec;
        if (cnt_dec == '0) state_d = PULSE_B;
      end
      PULSE_B: begin
        tog_b   = op_q.b;
        cnt_d   = CNT_W'(SETUP_CYC);
        state_d = GAP_S;
      end
      GAP_S: begin
        cnt_d = cnt_dec;
        if (cnt_dec == '0) state_d = PULSE_CLK;
      end
      PULSE_CLK: begin
        tog_clk = 1'b1;
        q_ref_d = q_sync_q;
        cnt_d   = CNT_W'(LAT_CYC);
        state_d = WAIT_Q;
      end
      WAIT_Q: begin
        cnt_d = cnt_dec;
        if (cnt_dec == '0) begin
          rsp_valid_d = 1'b1;
          rsp_bit_d   = q_bit;
          rsp_err_d   = q_bit ^ exp_q(op_q.a, op_q.b);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, line, synchroniser and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      q_s1_q      <= 1'b0;
      q_sync_q    <= 1'b0;
      q_ref_q     <= 1'b0;
      sfq_a_q     <= 1'b0;
      sfq_b_q     <= 1'b0;
      sfq_clk_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_bit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      q_s1_q      <= sfq_q;
      q_sync_q    <= q_s1_q;
      q_ref_q     <= q_ref_d;
      sfq_a_q     <= sfq_a_q ^ tog_a;
      sfq_b_q     <= sfq_b_q ^ tog_b;
      sfq_clk_q   <= sfq_clk_q ^ tog_clk;
      rsp_valid_q <= rsp_valid_d;
      rsp_bit_q   <= rsp_bit_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef SFQ_XORT_DRV_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q;

  // Saturating error count, updated on the same edge as the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (rsp_valid_d && rsp_err_d && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign sfq_a     = sfq_a_q;
  assign sfq_b     = sfq_b_q;
  assign sfq_clk   = sfq_clk_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_bit   = rsp_bit_q;
  assign rsp_err   = rsp_err_q;
  assign req_ready = !fifo_full;
  assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule
